ahb_mmio_fabric: RTL
====================

# ahb_mmio_fabric

Parametrised AHB-Lite single-master, N-slave MMIO fabric. It replaces the fixed MMIO decode between the processor's MMIO master port and the IO peripherals (UART, SPI, GPIO, and future slaves). It adds a configurable slave count, a default slave that returns AHB ERROR for unmapped addresses, and a per-transfer wait-state watchdog. The watchdog aborts hung slaves with an ERROR response and records the failing address.

## Interface
Parameters:
- NUM_SLAVES, 4: number of slave ports, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- REGION_LSB, 12: log2 of the region size in bytes per slave.
- BASE_ADDR, 32'h7000_0000: fabric base address. Bits below REGION_LSB+SEL_W are ignored.
- TIMEOUT_CYCLES, 256: maximum wait-state cycles per data phase. 0 disables the watchdog.

Ports (clock and reset first):
- HCLK, in, 1: fabric clock.
- HRESET, in, 1: reset, synchronous, active-high.
- HADDR_M0, in, ADDR_W: master address.
- HTRANS_M0, in, 2: master transfer type.
- HWRITE_M0, in, 1: master write.
- HSIZE_M0, in, 3: master transfer size.
- HWDATA_M0, in, DATA_W: master write data.
- HREADY_M0, out, 1: transfer done to master.
- HRESP_M0, out, 1: response to master. 1 = ERROR.
- HRDATA_M0, out, DATA_W: read data to master.
- HSEL_S, out, NUM_SLAVES: one-hot slave select, address phase.
- HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HWDATA_S, out: master signals broadcast to all slaves.
- HREADY_S, out, NUM_SLAVES: per-slave HREADY input.
- HREADYOUT_S, in, NUM_SLAVES: slave ready.
- HRESP_S, in, NUM_SLAVES: slave response.
- HRDATA_S, in, NUM_SLAVES*DATA_W: slave read data. Slave i occupies bits [i*DATA_W +: DATA_W].
- ERR_VALID, out, 1: one-cycle pulse when the fabric itself issues an ERROR.
- ERR_TIMEOUT, out, 1: qualifier for ERR_VALID. 1 = watchdog, 0 = unmapped or hung slave.
- ERR_ADDR, out, ADDR_W: address of the last fabric-generated error. Held until the next error.

## Operation
Decode:
- SEL_W = max(1, clog2(NUM_SLAVES)).
- idx = HADDR_M0[REGION_LSB +: SEL_W].
- A transfer is mapped when the upper bits HADDR_M0[ADDR_W-1 : REGION_LSB+SEL_W] equal the same bits of BASE_ADDR, idx < NUM_SLAVES, and hung[idx] = 0.

Address phase:
- Accepted when HTRANS_M0[1] = 1 and HREADY_M0 = 1.
- HSEL_S[idx] is asserted combinationally for mapped transfers. It is all-zero otherwise.
- IDLE and BUSY transfers get an OKAY response with zero wait states and are never forwarded.

State machine, registered state:
- IDLE: no data phase in progress.
  - Mapped NONSEQ/SEQ -> SLV, with dsel = idx latched.
  - Unmapped NONSEQ/SEQ -> ERR1.
- SLV:
  - HREADY_M0 = HREADYOUT_S[dsel], HRESP_M0 = HRESP_S[dsel], HRDATA_M0 = slice dsel.
  - Completes when HREADYOUT_S[dsel] = 1. The next state is decoded from the new address phase exactly as from IDLE.
  - Watchdog expiry -> ERR1 and set hung[dsel].
- ERR1: HREADY_M0 = 0, HRESP_M0 = 1. Pulse ERR_VALID; ERR_ADDR takes the latched data-phase address. -> ERR2.
- ERR2: HREADY_M0 = 1, HRESP_M0 = 1. Next state is decoded from the current address phase.

Watchdog and hung slaves:
- wcnt clears on every entry to SLV and increments each SLV cycle with HREADYOUT_S[dsel] = 0.
- Expiry occurs when wcnt == TIMEOUT_CYCLES-1 while the slave is still not ready.
- While hung[i] = 1: HREADY_S[i] = HREADYOUT_S[i], so the slave finishes its abandoned phase with HSEL_S[i] = 0. hung[i] clears on the cycle HREADYOUT_S[i] = 1.
- Transfers to a hung slave are treated as unmapped.
- When hung[i] = 0: HREADY_S[i] = HREADY_M0.

HRDATA_M0 is zero outside SLV.

## Timing
- Reset values: state = IDLE, hung = 0, wcnt = 0, ERR_VALID = 0, ERR_TIMEOUT = 0, ERR_ADDR = 0. In IDLE after reset, HREADY_M0 = 1 and HRESP_M0 = 0.
- Mapped transfer: data-phase latency equals the slave's latency. The fabric adds zero cycles.
- Unmapped transfer: exactly 2 data-phase cycles (ERR1, ERR2).
- Timeout: TIMEOUT_CYCLES wait cycles, then ERR1, then ERR2, so the master sees TIMEOUT_CYCLES+1 low-HREADY cycles.
- A slave's HREADYOUT rising on the same cycle as expiry counts as completion. No timeout is taken.
- HRESET asserted mid-transfer returns to IDLE on the next edge and clears hung. Slaves are reset by the same HRESET.
- Back-to-back pipelined transfers to different slaves need no idle cycle.

## Structure
- Package ahb_fabric_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP encodings (OKAY, ERROR).
  - the state enum.
  - the SEL_W helper function.
- One sub-module: ahb_fabric_watchdog (counter, expiry compare, disable when TIMEOUT_CYCLES = 0).

## Test plan
- Reset, then read slave 2 at 0x7000_2004 with 1 wait state -> HSEL_S = 4'b0100; HRDATA_M0 = slave-2 data after 2 data cycles; HRESP_M0 = 0.
- Write to 0x7000_5000 with NUM_SLAVES = 4 -> no HSEL_S; HREADY_M0 = 0,1 with HRESP_M0 = 1,1; ERR_VALID pulse; ERR_ADDR = 0x7000_5000; ERR_TIMEOUT = 0.
- TIMEOUT_CYCLES = 8, slave 1 holds HREADYOUT low for 20 cycles -> ERROR after 8 waits; ERR_TIMEOUT = 1; next access to slave 1 gets ERROR without HSEL; after the slave's ready, access to slave 1 succeeds.
- Pipelined NONSEQ to slave 0 then slave 3, zero wait -> completes in 2 consecutive cycles with correct data each.
- HRESET asserted during the ERR1 of a timeout -> next cycle IDLE, HREADY_M0 = 1, hung = 0, ERR_VALID = 0.
- TIMEOUT_CYCLES = 0, slave waits 1000 cycles -> no error; completes with slave response.

Source files
------------

// File: rtl/ahb_fabric_pkg.sv
// rtl/ahb_fabric_pkg.sv - shared encodings, state type and decode helper for the MMIO fabric
package ahb_fabric_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLV,
    ST_ERR1,
    ST_ERR2
  } fab_state_t;

  // Slave-index width; a single slave still gets one decode bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_fabric_watchdog.sv
// rtl/ahb_fabric_watchdog.sv - per-data-phase wait-state counter with expiry flag
module ahb_fabric_watchdog
  import ahb_fabric_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic EN = (TIMEOUT_CYCLES > 0);

  logic [CNT_W-1:0] wcnt;

  // Saturates at LAST: the phase is aborted on expiry, so further counts carry no meaning.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      wcnt <= '0;
    end else if (active && wcnt != LAST) begin
      wcnt <= wcnt + CNT_W'(1);
    end
  end

  assign expire = EN && active && (wcnt == LAST);

endmodule

// File: rtl/ahb_mmio_fabric.sv
// rtl/ahb_mmio_fabric.sv - AHB-Lite single-master N-slave MMIO decoder with default slave and watchdog
module ahb_mmio_fabric
  import ahb_fabric_pkg::*;
#(
  parameter int              NUM_SLAVES     = 4,
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              REGION_LSB     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h7000_0000,
  parameter int              TIMEOUT_CYCLES = 256
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [ADDR_W-1:0]            HADDR_M0,
  input  logic [1:0]                   HTRANS_M0,
  input  logic                         HWRITE_M0,
  input  logic [2:0]                   HSIZE_M0,
  input  logic [DATA_W-1:0]            HWDATA_M0,
  output logic                         HREADY_M0,
  output logic                         HRESP_M0,
  output logic [DATA_W-1:0]            HRDATA_M0,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  output logic [ADDR_W-1:0]            HADDR_S,
  output logic [1:0]                   HTRANS_S,
  output logic                         HWRITE_S,
  output logic [2:0]                   HSIZE_S,
  output logic [DATA_W-1:0]            HWDATA_S,
  output logic [NUM_SLAVES-1:0]        HREADY_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  output logic                         ERR_VALID,
  output logic                         ERR_TIMEOUT,
  output logic [ADDR_W-1:0]            ERR_ADDR
);

  localparam int SEL_W   = sel_width(NUM_SLAVES);
  localparam int NSEL    = 1 << SEL_W;
  localparam int TAG_LSB = REGION_LSB + SEL_W;

  fab_state_t             state, state_nxt, decode_st;
  logic [SEL_W-1:0]       idx, dsel;
  logic [ADDR_W-1:0]      daddr;
  logic [NUM_SLAVES-1:0]  hung, hung_set;
  logic [NSEL-1:0]        hung_ext, rdy_ext, resp_ext;
  logic [DATA_W-1:0]      rdata_sel;
  logic fwd, accept, tag_hit, mapped, rdy_sel, resp_sel;
  logic start, wd_active, expire;

  assign HADDR_S  = HADDR_M0;
  assign HTRANS_S = HTRANS_M0;
  assign HWRITE_S = HWRITE_M0;
  assign HSIZE_S  = HSIZE_M0;
  assign HWDATA_S = HWDATA_M0;

  assign idx     = HADDR_M0[REGION_LSB +: SEL_W];
  assign tag_hit = (HADDR_M0 >> TAG_LSB) == (BASE_ADDR >> TAG_LSB);
  assign fwd     = !(HTRANS_M0 == HTRANS_IDLE || HTRANS_M0 == HTRANS_BUSY);

  // Zero-extended views so an out-of-range index reads as "not present".
  always_comb begin
    hung_ext = '0;
    rdy_ext  = '0;
    resp_ext = '0;
    hung_ext[NUM_SLAVES-1:0] = hung;
    rdy_ext[NUM_SLAVES-1:0]  = HREADYOUT_S;
    resp_ext[NUM_SLAVES-1:0] = HRESP_S;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel == SEL_W'(i)) rdata_sel = HRDATA_S[i*DATA_W +: DATA_W];
    end
  end

  assign mapped   = tag_hit && (32'(idx) < NUM_SLAVES) && !hung_ext[idx];
  assign rdy_sel  = rdy_ext[dsel];
  assign resp_sel = resp_ext[dsel];

  assign HREADY_M0 = (state == ST_SLV) ? rdy_sel : (state != ST_ERR1);
  assign accept    = fwd && HREADY_M0;
  assign decode_st = !accept ? ST_IDLE : (mapped ? ST_SLV : ST_ERR1);

  // A hung slave is clocked by its own ready so it can drain the abandoned phase.
  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL_S[i]   = mapped && (idx == SEL_W'(i));
      HREADY_S[i] = hung[i] ? HREADYOUT_S[i] : HREADY_M0;
      hung_set[i] = expire && (dsel == SEL_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    HRESP_M0  = HRESP_OKAY;
    HRDATA_M0 = '0;
    case (state)
      ST_IDLE: state_nxt = decode_st;
      ST_SLV: begin
        HRESP_M0  = resp_sel;
        HRDATA_M0 = rdata_sel;
        if (rdy_sel)     state_nxt = decode_st;
        else if (expire) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HRESP_M0  = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP_M0  = HRESP_ERROR;
        state_nxt = decode_st;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign start     = (state_nxt == ST_SLV) && HREADY_M0;
  assign wd_active = (state == ST_SLV) && !rdy_sel;
  assign ERR_VALID = (state == ST_ERR1);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      dsel        <= '0;
      daddr       <= '0;
      hung        <= '0;
      ERR_TIMEOUT <= 1'b0;
      ERR_ADDR    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dsel  <= idx;
        daddr <= HADDR_M0;
      end
      hung <= (hung & ~HREADYOUT_S) | hung_set;
      // Error report is captured on entry so it is valid alongside ERR_VALID.
      if (state_nxt == ST_ERR1) begin
        ERR_TIMEOUT <= expire;
        ERR_ADDR    <= expire ? daddr : HADDR_M0;
      end
    end
  end

  ahb_fabric_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (HCLK),
    .rst   (HRESET),
    .start (start),
    .active(wd_active),
    .expire(expire)
  );

endmodule
